// File: rtl/divider.sv
// -----------------------------------------------------------------------------
// divider
// Iterative signed integer divider for the ALU. A start pulse latches a
// dividend/divisor pair; the unit then produces one quotient bit per clock
// with a restoring shift-subtract on operand magnitudes. It applies sign
// correction once at the end. The quotient truncates toward zero and the
// remainder takes the dividend's sign. Divide-by-zero and the single signed
// overflow case (most negative / -1) bypass the iteration and finish early.
//
// Ports
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   Start      request, accepted in IDLE or DONE only
//   In1        signed dividend, sampled on the accepting edge
//   In2        signed divisor, sampled on the accepting edge
//   Quotient   signed quotient (registered, held until the next result)
//   Remainder  signed remainder (registered, held until the next result)
//   Busy       high while an operation is in flight
//   Done       one-cycle pulse when results and flags are updated
//   DivByZero  divisor was zero for the completed operation
//   Overflow   operands were most-negative / -1 for the completed operation
// -----------------------------------------------------------------------------
module divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             Start,
    input  logic [WIDTH-1:0] In1,
    input  logic [WIDTH-1:0] In2,
    output logic [WIDTH-1:0] Quotient,
    output logic [WIDTH-1:0] Remainder,
    output logic             Busy,
    output logic             Done,
    output logic             DivByZero,
    output logic             Overflow
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] MinNeg = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } state_t;

    state_t            state_q,     state_d;
    logic [CW-1:0]     cnt_q,       cnt_d;
    logic [WIDTH-1:0]  rem_q,       rem_d;
    logic [WIDTH-1:0]  dvd_q,       dvd_d;
    logic [WIDTH-1:0]  dvs_q,       dvs_d;
    logic              negQuot_q,   negQuot_d;
    logic              negRem_q,    negRem_d;
    logic              special_q,   special_d;
    logic              divZero_q,   divZero_d;
    logic              ovf_q,       ovf_d;
    logic [WIDTH-1:0]  quot_q,      quot_d;
    logic [WIDTH-1:0]  remOut_q,    remOut_d;
    logic              busy_q,      busy_d;
    logic              done_q,      done_d;
    logic              divByZero_q, divByZero_d;
    logic              overflow_q,  overflow_d;

    logic [WIDTH-1:0]  in1Mag;
    logic [WIDTH-1:0]  in2Mag;
    logic [WIDTH:0]    remShift;
    logic [WIDTH:0]    trial;
    logic              isDivZero;
    logic              isOverflow;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rem_d       = rem_q;
        dvd_d       = dvd_q;
        dvs_d       = dvs_q;
        negQuot_d   = negQuot_q;
        negRem_d    = negRem_q;
        special_d   = special_q;
        divZero_d   = divZero_q;
        ovf_d       = ovf_q;
        quot_d      = quot_q;
        remOut_d    = remOut_q;
        divByZero_d = divByZero_q;
        overflow_d  = overflow_q;

        // Two's-complement negation in WIDTH bits maps the most negative
        // value onto 2^(WIDTH-1). That value is exact when the result is read
        // as unsigned, which is how the iteration treats the magnitudes.
        in1Mag     = In1[WIDTH-1] ? -In1 : In1;
        in2Mag     = In2[WIDTH-1] ? -In2 : In2;
        isDivZero  = (In2 == '0);
        isOverflow = (In1 == MinNeg) && (In2 == '1);

        // The partial remainder stays below the divisor magnitude, which is
        // at most 2^(WIDTH-1). So after the shift it fits in WIDTH bits, and
        // the extra top bit of the trial subtraction is its sign.
        remShift = {rem_q, dvd_q[WIDTH-1]};
        trial    = remShift - {1'b0, dvs_q};

        case (state_q)
            IDLE, DONE: begin
                if (Start) begin
                    negQuot_d = In1[WIDTH-1] ^ In2[WIDTH-1];
                    negRem_d  = In1[WIDTH-1];
                    divZero_d = isDivZero;
                    ovf_d     = isOverflow;
                    if (isDivZero) begin
                        special_d = 1'b1;
                        dvd_d     = '1;
                        rem_d     = In1;
                        state_d   = FIX;
                    end else if (isOverflow) begin
                        special_d = 1'b1;
                        dvd_d     = MinNeg;
                        rem_d     = '0;
                        state_d   = FIX;
                    end else begin
                        special_d = 1'b0;
                        cnt_d     = CW'(WIDTH - 1);
                        rem_d     = '0;
                        dvd_d     = in1Mag;
                        dvs_d     = in2Mag;
                        state_d   = CALC;
                    end
                end else begin
                    state_d = IDLE;
                end
            end

            CALC: begin
                // The dividend register shifts left. Its freed LSB collects
                // the quotient bits, so it holds the quotient magnitude once
                // all bits are done.
                if (!trial[WIDTH]) begin
                    rem_d = trial[WIDTH-1:0];
                    dvd_d = {dvd_q[WIDTH-2:0], 1'b1};
                end else begin
                    rem_d = remShift[WIDTH-1:0];
                    dvd_d = {dvd_q[WIDTH-2:0], 1'b0};
                end
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == '0) begin
                    state_d = FIX;
                end
            end

            FIX: begin
                // Special cases were preloaded with final values and must
                // not be sign-corrected.
                if (special_q) begin
                    quot_d   = dvd_q;
                    remOut_d = rem_q;
                end else begin
                    quot_d   = negQuot_q ? -dvd_q : dvd_q;
                    remOut_d = negRem_q  ? -rem_q : rem_q;
                end
                divByZero_d = divZero_q;
                overflow_d  = ovf_q;
                state_d     = DONE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // Busy and Done come from the next state, so both come straight
        // from flops.
        busy_d = (state_d == CALC) || (state_d == FIX);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            rem_q       <= '0;
            dvd_q       <= '0;
            dvs_q       <= '0;
            negQuot_q   <= 1'b0;
            negRem_q    <= 1'b0;
            special_q   <= 1'b0;
            divZero_q   <= 1'b0;
            ovf_q       <= 1'b0;
            quot_q      <= '0;
            remOut_q    <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            divByZero_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rem_q       <= rem_d;
            dvd_q       <= dvd_d;
            dvs_q       <= dvs_d;
            negQuot_q   <= negQuot_d;
            negRem_q    <= negRem_d;
            special_q   <= special_d;
            divZero_q   <= divZero_d;
            ovf_q       <= ovf_d;
            quot_q      <= quot_d;
            remOut_q    <= remOut_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            divByZero_q <= divByZero_d;
            overflow_q  <= overflow_d;
        end
    end

    assign Quotient  = quot_q;
    assign Remainder = remOut_q;
    assign Busy      = busy_q;
    assign Done      = done_q;
    assign DivByZero = divByZero_q;
    assign Overflow  = overflow_q;

endmodule

// File: tb/tb_divider.sv
// -----------------------------------------------------------------------------
// tb_divider
// Directed bench for the divider. Each request pushes its expected result,
// computed from the operands by a small behavioural model, onto a
// scoreboard queue. That entry is popped and compared when Done is seen.
// -----------------------------------------------------------------------------
module tb_divider;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        logic        dz;
        logic        ov;
        int          lat;
        int          busy;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        Start;
    logic [31:0] In1;
    logic [31:0] In2;
    logic [31:0] Quotient;
    logic [31:0] Remainder;
    logic        Busy;
    logic        Done;
    logic        DivByZero;
    logic        Overflow;

    int   testsRun    = 0;
    int   testsFailed = 0;
    exp_t sb[$];

    divider #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .Start     (Start),
        .In1       (In1),
        .In2       (In2),
        .Quotient  (Quotient),
        .Remainder (Remainder),
        .Busy      (Busy),
        .Done      (Done),
        .DivByZero (DivByZero),
        .Overflow  (Overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // The behavioural model uses the language's signed / and %, which
    // truncate toward zero. The two special cases are handled first.
    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        if (b == 32'd0) begin
            e.q = 32'hFFFF_FFFF; e.r = a; e.dz = 1'b1; e.ov = 1'b0; e.lat = 1;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            e.q = 32'h8000_0000; e.r = 32'd0; e.dz = 1'b0; e.ov = 1'b1; e.lat = 1;
        end else begin
            e.q  = 32'($signed(a) / $signed(b));
            e.r  = 32'($signed(a) % $signed(b));
            e.dz = 1'b0; e.ov = 1'b0; e.lat = 33;
        end
        e.busy = e.lat;
        return e;
    endfunction

    task automatic compare(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        testsRun++;
        assert (obs === expv) else begin
            testsFailed++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Drives one request. The accepting edge is the next rising edge. If
    // immediate is set, the request starts in the current cycle, which is
    // used for back-to-back issue during a Done cycle.
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b,
                                 input bit immediate, input bit expectResult);
        if (!immediate) @(negedge clk);
        Start = 1'b1;
        In1   = a;
        In2   = b;
        if (expectResult) sb.push_back(model(a, b));
        @(posedge clk);
        #1;
        Start = 1'b0;
        In1   = $urandom;
        In2   = $urandom;
    endtask

    // Call at accepting edge + 1. Waits up to a bounded number of edges for
    // Done, checks the result against the scoreboard, and optionally pulses
    // Start mid-operation. Without chaining, it also checks that Done is a
    // single-cycle pulse and that the results hold afterwards.
    task automatic checkOutput(input string tag, input int pulseAt, input bit chain);
        exp_t e;
        int   edges      = 0;
        int   busyCycles = 0;
        while (Done !== 1'b1 && edges < 100) begin
            Start = (edges == pulseAt);
            if (edges == pulseAt) begin
                In1 = 32'd555;
                In2 = 32'd5;
            end
            if (Busy === 1'b1) busyCycles++;
            @(posedge clk);
            #1;
            edges++;
        end
        Start = 1'b0;
        compare({tag, "_done_seen"}, {31'd0, Done}, 32'd1);
        if (sb.size() == 0) begin
            compare({tag, "_sb_entry"}, 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            compare({tag, "_quotient"},  Quotient,            e.q);
            compare({tag, "_remainder"}, Remainder,           e.r);
            compare({tag, "_divbyzero"}, {31'd0, DivByZero},  {31'd0, e.dz});
            compare({tag, "_overflow"},  {31'd0, Overflow},   {31'd0, e.ov});
            compare({tag, "_latency"},   32'(edges),          32'(e.lat));
            compare({tag, "_busy_len"},  32'(busyCycles),     32'(e.busy));
            compare({tag, "_busy_done"}, {31'd0, Busy},       32'd0);
            if (!chain) begin
                @(posedge clk);
                #1;
                compare({tag, "_done_pulse"}, {31'd0, Done},      32'd0);
                compare({tag, "_q_hold"},     Quotient,           e.q);
                compare({tag, "_r_hold"},     Remainder,          e.r);
                compare({tag, "_dz_hold"},    {31'd0, DivByZero}, {31'd0, e.dz});
            end
        end
    endtask

    initial begin
        int doneSeen;
        rst_n = 1'b0;
        Start = 1'b1;
        In1   = 32'd100;
        In2   = 32'd7;
        repeat (3) @(posedge clk);
        #1;
        compare("reset_busy",  {31'd0, Busy},      32'd0);
        compare("reset_done",  {31'd0, Done},      32'd0);
        compare("reset_q",     Quotient,           32'd0);
        compare("reset_r",     Remainder,          32'd0);
        compare("reset_flags", {30'd0, DivByZero, Overflow}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        Start = 1'b0;
        @(posedge clk);
        #1;
        compare("idle_busy", {31'd0, Busy}, 32'd0);

        applyStimulus(32'd100, 32'd7, 1'b0, 1'b1);
        checkOutput("p100_d7", -1, 1'b0);

        applyStimulus(-32'sd100, 32'd7, 1'b0, 1'b1);
        checkOutput("m100_d7", -1, 1'b0);

        applyStimulus(32'd100, -32'sd7, 1'b0, 1'b1);
        checkOutput("p100_dm7", -1, 1'b0);

        applyStimulus(-32'sd100, -32'sd7, 1'b0, 1'b1);
        checkOutput("m100_dm7", -1, 1'b1);
        applyStimulus(32'd9, 32'd4, 1'b1, 1'b1);
        checkOutput("b2b_9_4", -1, 1'b0);

        applyStimulus(32'h1234_5678, 32'd0, 1'b0, 1'b1);
        checkOutput("div_zero", -1, 1'b0);

        applyStimulus(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b1);
        checkOutput("overflow", -1, 1'b0);

        applyStimulus(32'h8000_0000, 32'd1, 1'b0, 1'b1);
        checkOutput("minneg_d1", -1, 1'b0);

        applyStimulus(32'h8000_0000, 32'd3, 1'b0, 1'b1);
        checkOutput("minneg_d3", -1, 1'b0);

        applyStimulus(32'd123456789, -32'sd1000, 1'b0, 1'b1);
        checkOutput("start_in_calc", 5, 1'b0);

        applyStimulus(32'd1000, 32'd3, 1'b0, 1'b0);
        repeat (9) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        compare("midrst_busy", {31'd0, Busy},      32'd0);
        compare("midrst_done", {31'd0, Done},      32'd0);
        compare("midrst_q",    Quotient,           32'd0);
        compare("midrst_r",    Remainder,          32'd0);
        compare("midrst_flags", {30'd0, DivByZero, Overflow}, 32'd0);
        doneSeen = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (Done === 1'b1) doneSeen++;
        end
        compare("midrst_no_done", 32'(doneSeen), 32'd0);

        applyStimulus(32'd1000, 32'd3, 1'b0, 1'b1);
        checkOutput("after_rst_1000_3", -1, 1'b0);

        compare("sb_empty", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
